// File: rtl/correlator_shot_sequencer_if.sv
// +----------------------------------------------------------------------+
// | correlator_shot_sequencer_if : sequencer <-> correlator handshake     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface correlator_shot_sequencer_if;
    logic        CorrStart;
    logic        CorrStop;
    logic        CorrDone;
    logic        CorrBright;
    logic [1:0]  CorrArrival;
    logic [31:0] CorrTimeSpan;

    modport master (
        output CorrStart,
        output CorrStop,
        input  CorrDone,
        input  CorrBright,
        input  CorrArrival,
        input  CorrTimeSpan
    );

    modport slave (
        input  CorrStart,
        input  CorrStop,
        output CorrDone,
        output CorrBright,
        output CorrArrival,
        output CorrTimeSpan
    );
endinterface

`default_nettype wire

// File: rtl/correlator_shot_sequencer.sv
// +----------------------------------------------------------------------+
// | correlator_shot_sequencer : N-shot batch controller with timeout,     |
// | statistics; SEQ_SPAN_SUM_EN builds the bright-shot span accumulator.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module correlator_shot_sequencer #(
    parameter int SHOT_W  = 16,
    parameter int HOLDOFF = 4,
    parameter int SPAN_W  = 48
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_Run,
    input  logic                  i_Abort,
    input  logic [SHOT_W-1:0]     i_NumShots,
    input  logic [31:0]           i_Timeout,
    correlator_shot_sequencer_if.master corr,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic [SHOT_W-1:0]     o_ShotCount,
    output logic [SHOT_W-1:0]     o_BrightCount,
    output logic [SHOT_W-1:0]     o_DarkCount,
    output logic [SHOT_W-1:0]     o_TimeoutCount,
    output logic [4*SHOT_W-1:0]   o_ArrHist,
    output logic [SPAN_W-1:0]     o_SpanSum
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_ACCUM  = 3'd4,
        S_HOLD   = 3'd5,
        S_DRAIN  = 3'd6,
        S_FINISH = 3'd7
    } state_t;

    localparam logic [31:0] c_HOLD_LAST = 32'(HOLDOFF - 1);

    state_t              state_q, state_d;
    logic [SHOT_W-1:0]   num_q, num_d;
    logic [31:0]         tmo_q, tmo_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [SHOT_W-1:0]   issued_q, issued_d;
    logic                start_q, start_d;
    logic                stop_q, stop_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [SHOT_W-1:0]   shot_q, shot_d;
    logic [SHOT_W-1:0]   bright_q, bright_d;
    logic [SHOT_W-1:0]   dark_q, dark_d;
    logic [SHOT_W-1:0]   tcnt_q, tcnt_d;
    logic [4*SHOT_W-1:0] hist_q, hist_d;
    logic                cap_bright_q, cap_bright_d;
    logic [1:0]          cap_arr_q, cap_arr_d;
    logic                cap_tflag_q, cap_tflag_d;
    logic                abort_seen_q, abort_seen_d;

    function automatic logic [SHOT_W-1:0] sat_inc(input logic [SHOT_W-1:0] v);
        return (&v) ? v : v + SHOT_W'(1);
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        tmo_d        = tmo_q;
        cnt_d        = cnt_q;
        issued_d     = issued_q;
        stop_d       = stop_q;
        shot_d       = shot_q;
        bright_d     = bright_q;
        dark_d       = dark_q;
        tcnt_d       = tcnt_q;
        hist_d       = hist_q;
        cap_bright_d = cap_bright_q;
        cap_arr_d    = cap_arr_q;
        cap_tflag_d  = cap_tflag_q;
        abort_seen_d = abort_seen_q;

        case (state_q)
            S_IDLE: begin
                if (i_Run && !i_Abort) state_d = S_ARM;
            end
            S_ARM: begin
                num_d        = i_NumShots;
                tmo_d        = i_Timeout;
                issued_d     = '0;
                shot_d       = '0;
                bright_d     = '0;
                dark_d       = '0;
                tcnt_d       = '0;
                hist_d       = '0;
                abort_seen_d = 1'b0;
                cnt_d        = '0;
                if (i_Abort || i_NumShots == '0) state_d = S_FINISH;
                else                             state_d = S_START;
            end
            S_START: begin
                // Counter runs from the start cycle so stop lands Timeout cycles after start.
                issued_d = sat_inc(issued_q);
                cnt_d    = sat_inc32(cnt_q);
                if (i_Abort) begin
                    stop_d  = 1'b1;
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = sat_inc32(cnt_q);
                if (corr.CorrDone) begin
                    cap_bright_d = corr.CorrBright;
                    cap_arr_d    = corr.CorrArrival;
                    cap_tflag_d  = stop_q;
                    abort_seen_d = i_Abort;
                    stop_d       = 1'b0;
                    state_d      = S_ACCUM;
                end else if (i_Abort) begin
                    stop_d  = 1'b1;
                    state_d = S_DRAIN;
                end else if (tmo_q != '0 && cnt_q >= tmo_q - 32'd1) begin
                    stop_d = 1'b1;
                end
            end
            S_ACCUM: begin
                if (cap_tflag_q) begin
                    tcnt_d = sat_inc(tcnt_q);
                end else begin
                    shot_d = sat_inc(shot_q);
                    if (cap_bright_q) bright_d = sat_inc(bright_q);
                    else              dark_d   = sat_inc(dark_q);
                    for (int k = 0; k < 4; k++) begin
                        if (cap_arr_q == 2'(k))
                            hist_d[k*SHOT_W +: SHOT_W] = sat_inc(hist_q[k*SHOT_W +: SHOT_W]);
                    end
                end
                cnt_d = '0;
                if (issued_q == num_q || abort_seen_q || i_Abort) state_d = S_FINISH;
                else                                             state_d = S_HOLD;
            end
            S_HOLD: begin
                if (i_Abort) begin
                    state_d = S_FINISH;
                end else if (cnt_q >= c_HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end else begin
                    cnt_d = sat_inc32(cnt_q);
                end
            end
            S_DRAIN: begin
                if (corr.CorrDone) begin
                    stop_d  = 1'b0;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pulse/level outputs follow the next state so they are registered yet state-aligned.
        start_d = (state_d == S_START);
        done_d  = (state_d == S_FINISH);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            num_q        <= '0;
            tmo_q        <= '0;
            cnt_q        <= '0;
            issued_q     <= '0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            shot_q       <= '0;
            bright_q     <= '0;
            dark_q       <= '0;
            tcnt_q       <= '0;
            hist_q       <= '0;
            cap_bright_q <= 1'b0;
            cap_arr_q    <= '0;
            cap_tflag_q  <= 1'b0;
            abort_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            tmo_q        <= tmo_d;
            cnt_q        <= cnt_d;
            issued_q     <= issued_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            shot_q       <= shot_d;
            bright_q     <= bright_d;
            dark_q       <= dark_d;
            tcnt_q       <= tcnt_d;
            hist_q       <= hist_d;
            cap_bright_q <= cap_bright_d;
            cap_arr_q    <= cap_arr_d;
            cap_tflag_q  <= cap_tflag_d;
            abort_seen_q <= abort_seen_d;
        end
    end

`ifdef SEQ_SPAN_SUM_EN
    logic [31:0]       cap_span_q, cap_span_d;
    logic [SPAN_W-1:0] span_q, span_d;
    logic [SPAN_W:0]   w_span_add;

    assign w_span_add = {1'b0, span_q} + (SPAN_W+1)'(cap_span_q);

    always_comb begin
        cap_span_d = cap_span_q;
        span_d     = span_q;
        if (state_q == S_ARM) begin
            span_d = '0;
        end else if (state_q == S_WAIT && corr.CorrDone) begin
            cap_span_d = corr.CorrTimeSpan;
        end else if (state_q == S_ACCUM && !cap_tflag_q && cap_bright_q) begin
            span_d = w_span_add[SPAN_W] ? '1 : w_span_add[SPAN_W-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cap_span_q <= '0;
            span_q     <= '0;
        end else begin
            cap_span_q <= cap_span_d;
            span_q     <= span_d;
        end
    end

    assign o_SpanSum = span_q;
`else
    logic w_unused_span;
    assign w_unused_span = ^corr.CorrTimeSpan;
    assign o_SpanSum     = '0;
`endif

    assign corr.CorrStart = start_q;
    assign corr.CorrStop  = stop_q;
    assign o_Busy         = busy_q;
    assign o_Done         = done_q;
    assign o_ShotCount    = shot_q;
    assign o_BrightCount  = bright_q;
    assign o_DarkCount    = dark_q;
    assign o_TimeoutCount = tcnt_q;
    assign o_ArrHist      = hist_q;

endmodule

`default_nettype wire
